// File: rtl/sga_render_pkg.sv
// Shared encodings and width helpers for the snake frame renderer,
// its LED matrix driver and benches.
package sga_render_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_READ    = 3'd2,
    S_DRAIN   = 3'd3,
    S_APPLE   = 3'd4,
    S_PUBLISH = 3'd5
  } state_e;

  // Index width for v distinct values; never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

  function automatic int cells_f(input int rows, input int cols);
    return rows * cols;
  endfunction

  function automatic int pw_f(input int rows, input int cols);
    return clog2_min1(rows * cols);
  endfunction

  function automatic int lw_f(input int max_len);
    return clog2_min1(max_len + 1);
  endfunction

  function automatic int aw_f(input int max_len);
    return clog2_min1(max_len);
  endfunction

endpackage

// File: rtl/snake_frame_renderer_if.sv
// Request, position-memory and LED-frame signals between the SGA datapath
// and the frame renderer.
interface snake_frame_renderer_if #(
  parameter int ROWS    = 6,
  parameter int COLS    = 6,
  parameter int MAX_LEN = 16
);
  localparam int CELLS = sga_render_pkg::cells_f(ROWS, COLS);
  localparam int PW    = sga_render_pkg::pw_f(ROWS, COLS);
  localparam int LW    = sga_render_pkg::lw_f(MAX_LEN);
  localparam int AW    = sga_render_pkg::aw_f(MAX_LEN);

  logic             render;
  logic [LW-1:0]    snake_size;
  logic [PW-1:0]    apple_pos;
  logic             apple_en;
  logic             blink_en;
  logic [AW-1:0]    pos_addr;
  logic [PW-1:0]    pos_data;
  logic [CELLS-1:0] leds;
  logic             busy;
  logic             done;
  logic             self_hit;
  logic [2:0]       db_state;

  modport master (
    output render, snake_size, apple_pos, apple_en, blink_en, pos_data,
    input  pos_addr, leds, busy, done, self_hit, db_state
  );

  modport slave (
    input  render, snake_size, apple_pos, apple_en, blink_en, pos_data,
    output pos_addr, leds, busy, done, self_hit, db_state
  );
endinterface

// File: rtl/render_blink_timer.sv
// Free-running head-blink timer: phase flips every BLINK_DIV clocks.
module render_blink_timer #(
  parameter int BLINK_DIV = 25000000
) (
  input  logic clock,
  input  logic restart,
  output logic phase_o
);
  localparam int CW = sga_render_pkg::clog2_min1(BLINK_DIV);
  localparam logic [CW-1:0] LAST = CW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    phase_d = phase_q;
    if (cnt_q == LAST) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clock or negedge restart) begin
    if (!restart) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;
endmodule

// File: rtl/snake_frame_renderer.sv
// Builds a ROWS x COLS LED frame from snake positions plus the apple and
// publishes it atomically, flagging head/body collisions.
module snake_frame_renderer
  import sga_render_pkg::*;
#(
  parameter int ROWS      = 6,
  parameter int COLS      = 6,
  parameter int MAX_LEN   = 16,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                   clock,
  input  logic                   restart,
  snake_frame_renderer_if.slave  bus
);
  localparam int CELLS = cells_f(ROWS, COLS);
  localparam int PW    = pw_f(ROWS, COLS);
  localparam int LW    = lw_f(MAX_LEN);
  localparam int AW    = aw_f(MAX_LEN);
  localparam int PW1   = PW + 1;
  localparam logic [PW:0]   CELLS_W = PW1'(CELLS);
  localparam logic [LW-1:0] MAX_N   = LW'(MAX_LEN);

  function automatic logic in_range(input logic [PW-1:0] p);
    return {1'b0, p} < CELLS_W;
  endfunction

  state_e           state_q;
  logic [LW-1:0]    n_q;
  logic [PW-1:0]    apple_q;
  logic             apple_en_q;
  logic [AW-1:0]    idx_q;
  logic [AW-1:0]    pos_addr_q;
  logic             first_q;
  logic [PW-1:0]    head_q;
  logic             hit_q;
  logic [CELLS-1:0] work_q;
  logic             busy_q, done_q, self_hit_q;

  logic [CELLS-1:0] frame_q, frame_d, leds_q, leds_d;
  logic [PW-1:0]    phead_q, phead_d;
  logic             pblink_q, pblink_d;
  logic             phase;

  logic          seg_vld, last_idx, head_blinkable;
  logic [LW-1:0] idx_ext;

  render_blink_timer #(.BLINK_DIV(BLINK_DIV)) u_blink (
    .clock   (clock),
    .restart (restart),
    .phase_o (phase)
  );

  // Read data trails the address by one cycle: READ cycle 0 has nothing yet,
  // DRAIN catches the final segment.
  assign idx_ext  = LW'(idx_q);
  assign last_idx = (idx_ext == n_q - LW'(1));
  assign seg_vld  = (state_q == S_READ && idx_q != '0) || (state_q == S_DRAIN);

  assign head_blinkable = (n_q != '0) && in_range(head_q) &&
                          !(apple_en_q && apple_q == head_q);

  always_ff @(posedge clock or negedge restart) begin
    if (!restart) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      apple_q    <= '0;
      apple_en_q <= 1'b0;
      idx_q      <= '0;
      pos_addr_q <= '0;
      first_q    <= 1'b0;
      head_q     <= '0;
      hit_q      <= 1'b0;
      work_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      self_hit_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: if (bus.render) begin
          state_q    <= S_CLEAR;
          busy_q     <= 1'b1;
          n_q        <= (bus.snake_size > MAX_N) ? MAX_N : bus.snake_size;
          apple_q    <= bus.apple_pos;
          apple_en_q <= bus.apple_en;
        end
        S_CLEAR: begin
          work_q     <= '0;
          hit_q      <= 1'b0;
          idx_q      <= '0;
          pos_addr_q <= '0;
          first_q    <= 1'b1;
          state_q    <= (n_q == '0) ? S_APPLE : S_READ;
        end
        S_READ: begin
          if (last_idx) begin
            state_q <= S_DRAIN;
          end else begin
            idx_q      <= idx_q + 1'b1;
            pos_addr_q <= idx_q + 1'b1;
          end
        end
        S_DRAIN: state_q <= S_APPLE;
        S_APPLE: begin
          if (apple_en_q && in_range(apple_q)) work_q[apple_q] <= 1'b1;
          state_q <= S_PUBLISH;
        end
        S_PUBLISH: begin
          busy_q     <= 1'b0;
          done_q     <= 1'b1;
          self_hit_q <= hit_q;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      if (seg_vld) begin
        first_q <= 1'b0;
        if (first_q) head_q <= bus.pos_data;
        if (in_range(bus.pos_data)) begin
          work_q[bus.pos_data] <= 1'b1;
          if (!first_q && bus.pos_data == head_q) hit_q <= 1'b1;
        end
      end
    end
  end

  // leds follows the frame being published this cycle so it lands with done.
  always_comb begin
    frame_d  = frame_q;
    phead_d  = phead_q;
    pblink_d = pblink_q;
    if (state_q == S_PUBLISH) begin
      frame_d  = work_q;
      phead_d  = head_q;
      pblink_d = head_blinkable;
    end
    leds_d = frame_d;
    if (bus.blink_en && !phase && pblink_d) leds_d[phead_d] = 1'b0;
  end

  always_ff @(posedge clock or negedge restart) begin
    if (!restart) begin
      frame_q  <= '0;
      phead_q  <= '0;
      pblink_q <= 1'b0;
      leds_q   <= '0;
    end else begin
      frame_q  <= frame_d;
      phead_q  <= phead_d;
      pblink_q <= pblink_d;
      leds_q   <= leds_d;
    end
  end

  assign bus.pos_addr = pos_addr_q;
  assign bus.leds     = leds_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.self_hit = self_hit_q;
  assign bus.db_state = state_q;
endmodule

// File: tb/tb_snake_frame_renderer.sv
// Directed bench: table of frames plus hand sequences for clamping,
// ignored renders, mid-frame restart, head blink and an 8x8 matrix.
module tb_snake_frame_renderer;
  import sga_render_pkg::*;

  logic clock = 1'b0;
  logic restart;
  always #5 clock = ~clock;

  snake_frame_renderer_if #(.ROWS(6), .COLS(6), .MAX_LEN(16)) bus ();
  snake_frame_renderer #(.ROWS(6), .COLS(6), .MAX_LEN(16), .BLINK_DIV(4)) dut (
    .clock(clock), .restart(restart), .bus(bus));

  snake_frame_renderer_if #(.ROWS(8), .COLS(8), .MAX_LEN(4)) bus2 ();
  snake_frame_renderer #(.ROWS(8), .COLS(8), .MAX_LEN(4), .BLINK_DIV(4)) dut2 (
    .clock(clock), .restart(restart), .bus(bus2));

  logic [5:0] mem  [16];
  logic [5:0] mem2 [4];
  always @(posedge clock) bus.pos_data  <= mem[bus.pos_addr];
  always @(posedge clock) bus2.pos_data <= mem2[bus2.pos_addr];

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          size;
    logic [5:0]  pos [5];
    logic [5:0]  apple;
    logic        aen;
    logic [35:0] leds;
    logic        hit;
    int          lat;
  } vec_t;
  vec_t tv [6];

  task automatic set_vec(input int i, input int size, input int p0, input int p1,
                         input int p2, input int p3, input int p4, input int apple,
                         input logic aen, input logic [35:0] leds, input logic hit,
                         input int lat);
    tv[i].size = size;
    tv[i].pos[0] = 6'(p0); tv[i].pos[1] = 6'(p1); tv[i].pos[2] = 6'(p2);
    tv[i].pos[3] = 6'(p3); tv[i].pos[4] = 6'(p4);
    tv[i].apple = 6'(apple); tv[i].aen = aen;
    tv[i].leds = leds; tv[i].hit = hit; tv[i].lat = lat;
  endtask

  // Pulse render, then scramble inputs to prove they were latched.
  task automatic run_frame(input int size, input logic [5:0] apple, input logic aen,
                           output int lat, output int bcyc, output int naddr,
                           output bit aok);
    @(negedge clock);
    bus.snake_size = 5'(size); bus.apple_pos = apple; bus.apple_en = aen;
    bus.render = 1'b1;
    @(negedge clock);
    bus.render = 1'b0;
    bus.snake_size = 5'd1; bus.apple_pos = 6'd1; bus.apple_en = ~aen;
    lat = 0; bcyc = 0; naddr = 0; aok = 1'b1;
    while (!bus.done && lat < 100) begin
      if (bus.busy) bcyc++;
      if (bus.db_state == S_READ) begin
        if (int'(bus.pos_addr) != naddr) aok = 1'b0;
        naddr++;
      end
      @(negedge clock);
      lat++;
    end
  endtask

  int lat, bcyc, naddr, dcnt, dlat, tr;
  bit aok, others_ok, alt_ok, const_ok;
  logic [35:0] cap;
  logic s [16];

  task automatic sample_blink(input logic [35:0] other_mask);
    others_ok = 1'b1;
    for (int c = 0; c < 16; c++) begin
      s[c] = bus.leds[14];
      if ((bus.leds & ~other_mask) != '0) others_ok = 1'b0;
      @(negedge clock);
    end
  endtask

  initial begin
    restart = 1'b1;
    bus.render = 0; bus.snake_size = '0; bus.apple_pos = '0; bus.apple_en = 0; bus.blink_en = 0;
    bus2.render = 0; bus2.snake_size = '0; bus2.apple_pos = '0; bus2.apple_en = 0; bus2.blink_en = 0;
    for (int k = 0; k < 16; k++) mem[k] = '0;
    for (int k = 0; k < 4; k++) mem2[k] = '0;
    #2 restart = 1'b0;
    @(negedge clock); @(negedge clock);
    chk("rst_leds", bus.leds, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_hit", bus.self_hit, 0);
    chk("rst_addr", bus.pos_addr, 0);
    chk("rst_state", bus.db_state, 0);
    restart = 1'b1;

    set_vec(0, 3, 14, 13, 12,  0,  0,  0, 1'b1, 36'h000007001, 1'b0, 7);
    set_vec(1, 4,  7,  8,  2,  7,  0,  0, 1'b0, 36'h000000184, 1'b1, 8);
    set_vec(2, 0,  0,  0,  0,  0,  0, 35, 1'b1, 36'h800000000, 1'b0, 3);
    set_vec(3, 0,  0,  0,  0,  0,  0, 35, 1'b0, 36'h000000000, 1'b0, 3);
    set_vec(4, 5, 40,  3, 40,  3, 50, 36, 1'b1, 36'h000000008, 1'b0, 9);
    set_vec(5, 2,  5,  5,  0,  0,  0,  5, 1'b1, 36'h000000020, 1'b1, 6);

    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 5; k++) mem[k] = tv[i].pos[k];
      run_frame(tv[i].size, tv[i].apple, tv[i].aen, lat, bcyc, naddr, aok);
      chk($sformatf("v%0d_lat", i), lat, tv[i].lat);
      chk($sformatf("v%0d_leds", i), bus.leds, tv[i].leds);
      chk($sformatf("v%0d_hit", i), bus.self_hit, tv[i].hit);
      chk($sformatf("v%0d_busy", i), bcyc, tv[i].lat);
      chk($sformatf("v%0d_nreads", i), naddr, tv[i].size);
      chk($sformatf("v%0d_addrseq", i), aok, 1);
    end

    // Oversized snake clamps to 16 reads; a render while busy is dropped.
    for (int k = 0; k < 16; k++) mem[k] = 6'(20 + k);
    @(negedge clock);
    bus.snake_size = 5'd20; bus.apple_en = 1'b0; bus.render = 1'b1;
    @(negedge clock);
    dcnt = 0; dlat = -1; naddr = 0; aok = 1'b1; cap = '0;
    for (int c = 0; c < 30; c++) begin
      bus.render = (c == 5);
      if (bus.done) begin
        dcnt++;
        if (dlat < 0) begin dlat = c; cap = bus.leds; end
      end
      if (bus.db_state == S_READ) begin
        if (int'(bus.pos_addr) != naddr) aok = 1'b0;
        naddr++;
      end
      @(negedge clock);
    end
    bus.render = 1'b0;
    chk("clamp_lat", dlat, 20);
    chk("clamp_ndone", dcnt, 1);
    chk("clamp_nreads", naddr, 16);
    chk("clamp_addrseq", aok, 1);
    chk("clamp_leds", cap, 36'hFFFF00000);

    // Restart in cycle 3 of a size-5 frame.
    for (int k = 0; k < 5; k++) mem[k] = 6'(k + 1);
    @(negedge clock);
    bus.snake_size = 5'd5; bus.render = 1'b1;
    @(negedge clock);
    bus.render = 1'b0;
    repeat (3) @(negedge clock);
    restart = 1'b0;
    #1;
    chk("abort_leds", bus.leds, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_state", bus.db_state, 0);
    chk("abort_addr", bus.pos_addr, 0);
    @(negedge clock);
    restart = 1'b1;
    dcnt = 0;
    for (int c = 0; c < 15; c++) begin
      if (bus.done) dcnt++;
      @(negedge clock);
    end
    chk("abort_nodone", dcnt, 0);
    run_frame(5, 6'd0, 1'b0, lat, bcyc, naddr, aok);
    chk("after_lat", lat, 9);
    chk("after_leds", bus.leds, 36'h00000003E);

    // Head blink at 14: 4 cycles off / 4 on, nothing else moves.
    mem[0] = 6'd14;
    bus.blink_en = 1'b1;
    run_frame(1, 6'd0, 1'b0, lat, bcyc, naddr, aok);
    chk("blink_lat", lat, 5);
    sample_blink(36'h000004000);
    alt_ok = 1'b1; tr = 0;
    for (int c = 1; c < 16; c++) if (s[c] != s[c-1]) tr++;
    for (int c = 4; c < 16; c++) if (s[c] == s[c-4]) alt_ok = 1'b0;
    chk("blink_period", alt_ok, 1);
    chk("blink_runs", (tr == 3 || tr == 4), 1);
    chk("blink_others", others_ok, 1);

    // Apple on the head cell keeps it lit.
    run_frame(1, 6'd14, 1'b1, lat, bcyc, naddr, aok);
    sample_blink(36'h000004000);
    const_ok = 1'b1;
    for (int c = 0; c < 16; c++) if (s[c] !== 1'b1) const_ok = 1'b0;
    chk("blink_apple_head", const_ok, 1);
    chk("blink_apple_others", others_ok, 1);

    // Empty snake: stale head must not blink the apple at 14.
    run_frame(0, 6'd14, 1'b1, lat, bcyc, naddr, aok);
    sample_blink(36'h000004000);
    const_ok = 1'b1;
    for (int c = 0; c < 16; c++) if (s[c] !== 1'b1) const_ok = 1'b0;
    chk("blink_empty", const_ok, 1);
    bus.blink_en = 1'b0;

    // 8x8 matrix with the head in the last cell.
    mem2[0] = 6'd63;
    @(negedge clock);
    bus2.snake_size = 3'd1; bus2.render = 1'b1;
    @(negedge clock);
    bus2.render = 1'b0;
    lat = 0;
    while (!bus2.done && lat < 50) begin
      @(negedge clock);
      lat++;
    end
    chk("m8_lat", lat, 5);
    chk("m8_leds", bus2.leds, 64'h8000000000000000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
